nand_cmd_addr_seq: RTL and testbench

Sequences NAND command and address latch cycles for one x8 bus. It generates registered ctrl_cen/ctrl_cle/ctrl_ale/ctrl_wrn/ctrl_wpn and the DQ output byte, which feed the per-bus IOB flop stage that drives the package pins. Upstream page/erase FSMs issue one byte per valid/ready handshake. The block holds the chip enable asserted across a multi-byte transaction and enforces setup, WE# low, WE# high and CE-hold timing in clk0 cycles.

---
 rtl/nand_phy_pkg.sv | 35 +++
 rtl/nand_cmd_addr_seq_if.sv | 25 ++
 rtl/nand_timing_cnt.sv | 21 ++
 rtl/nand_cmd_addr_seq.sv | 127 ++++++++++++
 tb/tb_nand_cmd_addr_seq.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/nand_phy_pkg.sv
// nand_phy_pkg: shared state encoding, default timings and request type for the NAND PHY sequencers
package nand_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WE_LOW,
        ST_WE_HIGH,
        ST_OPEN,
        ST_CLOSE
    } seq_state_t;

    localparam int CENS_PER_BUS_DEF = 8;
    localparam int T_SETUP_DEF      = 2;
    localparam int T_WP_DEF         = 3;
    localparam int T_WH_DEF         = 2;
    localparam int T_CEH_DEF        = 2;
    localparam int CE_W             = $clog2(CENS_PER_BUS_DEF);

    typedef struct packed {
        logic [CE_W-1:0] ce;
        logic            is_addr;
        logic            last;
        logic [7:0]      cmd_byte;
    } cmd_req_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int ab;
        int cd;
        ab = (a > b) ? a : b;
        cd = (c > d) ? c : d;
        return (ab > cd) ? ab : cd;
    endfunction

endpackage

// File: rtl/nand_cmd_addr_seq_if.sv
// nand_cmd_addr_seq_if: byte request handshake between upstream page/erase FSMs and the sequencer
interface nand_cmd_addr_seq_if #(
    parameter int CENS_PER_BUS = 8
);
    localparam int CEW = $clog2(CENS_PER_BUS);

    logic           req_valid;
    logic           req_ready;
    logic [CEW-1:0] req_ce;
    logic           req_is_addr;
    logic           req_last;
    logic [7:0]     req_byte;
    logic           wp_n_req;

    modport master (
        output req_valid, req_ce, req_is_addr, req_last, req_byte, wp_n_req,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_ce, req_is_addr, req_last, req_byte, wp_n_req,
        output req_ready
    );

endinterface

// File: rtl/nand_timing_cnt.sv
// nand_timing_cnt: loadable down-counter that parks at zero and flags it
module nand_timing_cnt #(
    parameter int W = 3
) (
    input  logic         clk0,
    input  logic         rst0,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load wins over decrement; once at zero the count holds until the next load
    always_ff @(posedge clk0) begin
        cnt <= rst0 ? '0 : load ? load_val : (cnt != '0) ? cnt - W'(1) : cnt;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/nand_cmd_addr_seq.sv
// nand_cmd_addr_seq: sequences NAND command/address latch cycles with CE# held across a transaction
module nand_cmd_addr_seq
    import nand_phy_pkg::*;
#(
    parameter int CENS_PER_BUS = CENS_PER_BUS_DEF,
    parameter int T_SETUP      = T_SETUP_DEF,
    parameter int T_WP         = T_WP_DEF,
    parameter int T_WH         = T_WH_DEF,
    parameter int T_CEH        = T_CEH_DEF
) (
    input  logic                    clk0,
    input  logic                    rst0,
    nand_cmd_addr_seq_if.slave      bus,
    output logic                    ctrl_cle,
    output logic                    ctrl_ale,
    output logic                    ctrl_wrn,
    output logic                    ctrl_wpn,
    output logic [CENS_PER_BUS-1:0] ctrl_cen,
    output logic [7:0]              dq_out,
    output logic                    dq_oe,
    output logic                    busy
);

    localparam int CEW   = $clog2(CENS_PER_BUS);
    localparam int CNT_W = $clog2(max4(T_SETUP, T_WP, T_WH, T_CEH)) + 1;

    seq_state_t              state_q;
    seq_state_t              state_n;
    cmd_req_t                req;
    logic                    accept;
    logic                    ready_q;
    logic                    ready_n;
    logic                    busy_n;
    logic                    cnt_zero;
    logic                    cnt_load;
    logic [CNT_W-1:0]        cnt_val;
    logic [CEW-1:0]          ce_q;
    logic [CEW-1:0]          ce_sel;
    logic                    last_q;
    logic [CENS_PER_BUS-1:0] cen_n;
    logic                    cle_n;
    logic                    ale_n;
    logic                    wrn_n;
    logic                    wpn_n;
    logic [7:0]              dq_n;
    logic                    oe_n;

    assign req = '{ce: bus.req_ce, is_addr: bus.req_is_addr, last: bus.req_last, cmd_byte: bus.req_byte};
    assign accept = bus.req_valid & ready_q;
    assign bus.req_ready = ready_q;

    // Every state change reloads the counter with that state's duration minus one
    assign cnt_load = (state_n != state_q);
    assign cnt_val  = (state_n == ST_SETUP)   ? CNT_W'(T_SETUP - 1) :
                      (state_n == ST_WE_LOW)  ? CNT_W'(T_WP - 1)    :
                      (state_n == ST_WE_HIGH) ? CNT_W'(T_WH - 1)    :
                      (state_n == ST_CLOSE)   ? CNT_W'(T_CEH - 1)   : '0;

    nand_timing_cnt #(.W(CNT_W)) u_cnt (
        .clk0     (clk0),
        .rst0     (rst0),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // State and registered outputs; reset aborts any cycle in flight on the same edge
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q  <= ST_IDLE;
            ce_q     <= '0;
            last_q   <= 1'b0;
            ctrl_cen <= '1;
            ctrl_cle <= 1'b0;
            ctrl_ale <= 1'b0;
            ctrl_wrn <= 1'b1;
            ctrl_wpn <= 1'b0;
            dq_out   <= '0;
            dq_oe    <= 1'b0;
            ready_q  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_n;
            ce_q     <= (accept && state_q == ST_IDLE) ? req.ce : ce_q;
            last_q   <= accept ? req.last : last_q;
            ctrl_cen <= cen_n;
            ctrl_cle <= cle_n;
            ctrl_ale <= ale_n;
            ctrl_wrn <= wrn_n;
            ctrl_wpn <= wpn_n;
            dq_out   <= dq_n;
            dq_oe    <= oe_n;
            ready_q  <= ready_n;
            busy     <= busy_n;
        end
    end

    // Next state: timed states leave when the counter reaches zero, IDLE/OPEN leave on accept
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE, ST_OPEN: state_n = accept ? ST_SETUP : state_q;
            ST_SETUP:         state_n = cnt_zero ? ST_WE_LOW : ST_SETUP;
            ST_WE_LOW:        state_n = cnt_zero ? ST_WE_HIGH : ST_WE_LOW;
            ST_WE_HIGH:       state_n = cnt_zero ? (last_q ? ST_CLOSE : ST_OPEN) : ST_WE_HIGH;
            ST_CLOSE:         state_n = cnt_zero ? ST_IDLE : ST_CLOSE;
            default:          state_n = ST_IDLE;
        endcase
    end

    // Output next values; inside a transaction the held CE wins over whatever req_ce shows
    always_comb begin
        ce_sel  = (state_q == ST_IDLE) ? req.ce : ce_q;
        cen_n   = accept ? ~(CENS_PER_BUS'(1) << ce_sel) :
                  (state_q == ST_CLOSE && cnt_zero) ? '1 : ctrl_cen;
        cle_n   = accept ? !req.is_addr : (state_q == ST_WE_HIGH && cnt_zero) ? 1'b0 : ctrl_cle;
        ale_n   = accept ? req.is_addr : (state_q == ST_WE_HIGH && cnt_zero) ? 1'b0 : ctrl_ale;
        oe_n    = accept ? 1'b1 : (state_q == ST_WE_HIGH && cnt_zero) ? 1'b0 : dq_oe;
        dq_n    = accept ? req.cmd_byte : dq_out;
        wrn_n   = (state_q == ST_SETUP && cnt_zero) ? 1'b0 :
                  (state_q == ST_WE_LOW && cnt_zero) ? 1'b1 : ctrl_wrn;
        wpn_n   = (state_q == ST_IDLE && !accept) ? bus.wp_n_req : ctrl_wpn;
        ready_n = (state_n == ST_IDLE) || (state_n == ST_OPEN);
        busy_n  = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_nand_cmd_addr_seq.sv
// tb_nand_cmd_addr_seq: directed and randomized checks against a timeline model of the latch cycles
module tb_nand_cmd_addr_seq;

    localparam int TS   = 2;
    localparam int TWP  = 3;
    localparam int TWH  = 2;
    localparam int TCEH = 2;
    localparam int P    = TS + TWP + TWH + 1;

    logic       clk0 = 1'b0;
    logic       rst0 = 1'b1;
    logic       ctrl_cle;
    logic       ctrl_ale;
    logic       ctrl_wrn;
    logic       ctrl_wpn;
    logic [7:0] ctrl_cen;
    logic [7:0] dq_out;
    logic       dq_oe;
    logic       busy;

    logic [7:0] bt[16];
    logic       isa[16];
    logic       wpn_m;
    int         checks = 0;
    int         failures = 0;
    int         step_id = 0;

    nand_cmd_addr_seq_if #(.CENS_PER_BUS(8)) bus ();

    nand_cmd_addr_seq dut (
        .clk0     (clk0),
        .rst0     (rst0),
        .bus      (bus),
        .ctrl_cle (ctrl_cle),
        .ctrl_ale (ctrl_ale),
        .ctrl_wrn (ctrl_wrn),
        .ctrl_wpn (ctrl_wpn),
        .ctrl_cen (ctrl_cen),
        .dq_out   (dq_out),
        .dq_oe    (dq_oe),
        .busy     (busy)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_id, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cen"}, ctrl_cen, 8'hFF);
        chk({tag, "_cle"}, ctrl_cle, 1'b0);
        chk({tag, "_ale"}, ctrl_ale, 1'b0);
        chk({tag, "_wrn"}, ctrl_wrn, 1'b1);
        chk({tag, "_wpn"}, ctrl_wpn, 1'b0);
        chk({tag, "_dq"}, dq_out, 8'h00);
        chk({tag, "_oe"}, dq_oe, 1'b0);
        chk({tag, "_rdy"}, bus.req_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic idle_step();
        @(posedge clk0);
        #1;
        step_id++;
        wpn_m = bus.wp_n_req;
        chk("idle_wpn", ctrl_wpn, wpn_m);
        chk("idle_rdy", bus.req_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_cen", ctrl_cen, 8'hFF);
        chk("idle_wrn", ctrl_wrn, 1'b1);
        chk("idle_oe", dq_oe, 1'b0);
    endtask

    // Byte j is accepted at offset j*P from the first accept; WE# is low for offsets
    // [TS, TS+TWP) of each byte, CLE/ALE/DQ-enable last until TS+TWP+TWH, and after the
    // last byte CE# stays low for TCEH more cycles before the sequencer is idle again.
    task automatic run_txn(input int ce, input int n, input int chain_ce,
                           input int wp_k, input logic wp_v, input int rst_k);
        int         last_end;
        int         endk;
        int         j;
        int         r;
        logic [7:0] cen_e;
        logic       lat;
        last_end = (n - 1) * P + TS + TWP + TWH;
        endk     = last_end + TCEH;
        cen_e    = ~(8'd1 << ce);
        bus.req_valid   = 1'b1;
        bus.req_ce      = 3'(ce);
        bus.req_is_addr = isa[0];
        bus.req_byte    = bt[0];
        bus.req_last    = (n == 1);
        for (int k = 0; k <= endk; k++) begin
            @(posedge clk0);
            #1;
            step_id++;
            if (k == rst_k) begin
                chk_reset("abort");
                rst0 = 1'b0;
                bus.req_valid = 1'b0;
                break;
            end
            j   = (k / P > n - 1) ? n - 1 : k / P;
            r   = k - j * P;
            lat = (k < last_end) && (r < P - 1);
            chk("cen", ctrl_cen, (k < endk) ? cen_e : 8'hFF);
            chk("busy", busy, k < endk);
            chk("rdy", bus.req_ready, (k == endk) || (k < last_end && r == P - 1));
            chk("wrn", ctrl_wrn, !(k < last_end && r >= TS && r < TS + TWP));
            chk("cle", ctrl_cle, lat && !isa[j]);
            chk("ale", ctrl_ale, lat && isa[j]);
            chk("oe", dq_oe, lat);
            chk("dq", dq_out, bt[j]);
            chk("wpn", ctrl_wpn, wpn_m);
            if (r == 0 && k < last_end) begin
                if (j + 1 < n) begin
                    bus.req_ce      = 3'(chain_ce);
                    bus.req_is_addr = isa[j + 1];
                    bus.req_byte    = bt[j + 1];
                    bus.req_last    = (j + 1 == n - 1);
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (k == wp_k) bus.wp_n_req = wp_v;
            if (k + 1 == rst_k) rst0 = 1'b1;
        end
        if (rst_k >= 0) wpn_m = 1'b0;
        idle_step();
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_ce      = '0;
        bus.req_is_addr = 1'b0;
        bus.req_last    = 1'b0;
        bus.req_byte    = '0;
        bus.wp_n_req    = 1'b0;
        wpn_m           = 1'b0;
        rst0            = 1'b1;
        repeat (2) begin
            @(posedge clk0);
            #1;
            step_id++;
            chk_reset("rst");
        end
        rst0 = 1'b0;
        idle_step();

        bt[0] = 8'hFF; isa[0] = 1'b0;
        run_txn(3, 1, 3, -1, 1'b0, -1);

        bt[0] = 8'h00; isa[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bt[i]  = 8'(8'hA0 + i);
            isa[i] = 1'b1;
        end
        bt[6] = 8'h30; isa[6] = 1'b0;
        run_txn(0, 7, 0, -1, 1'b0, -1);

        bt[0] = 8'h80; isa[0] = 1'b0;
        bt[1] = 8'h12; isa[1] = 1'b1;
        bt[2] = 8'h10; isa[2] = 1'b0;
        run_txn(2, 3, 5, -1, 1'b0, -1);

        bt[0] = 8'h60; isa[0] = 1'b0;
        run_txn(1, 1, 1, TS, 1'b1, -1);
        bus.wp_n_req = 1'b0;
        idle_step();
        bus.wp_n_req = 1'b1;
        idle_step();

        bt[0] = 8'h70; isa[0] = 1'b0;
        bt[1] = 8'h55; isa[1] = 1'b1;
        run_txn(4, 2, 4, -1, 1'b0, TS + 2);
        run_txn(4, 2, 4, -1, 1'b0, -1);

        for (int t = 0; t < 12; t++) begin
            int n;
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                bt[i]  = 8'($urandom);
                isa[i] = 1'($urandom);
            end
            run_txn(int'($urandom_range(0, 7)), n, int'($urandom_range(0, 7)),
                    int'($urandom_range(0, n * P)), 1'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
